rv_iopmp_check_arbiter: RTL and testbench
=========================================

# rv_iopmp_check_arbiter

Shares one IOPMP transaction-logic checker among NUM_REQ requesters, such as the AW and AR paths of one or more data abstractors. It grants one requester at a time using round-robin order, then forwards the latched check to the checker. It returns the allow/deny result to the granted requester only. A watchdog denies any check the checker fails to answer within a bounded time.

## Interface
- NUM_REQ, 2: number of requesters; must be ≥ 2.
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 64: bus width; num_bytes width is $clog2(DATA_WIDTH/8)+1.
- SID_WIDTH, 1: source-ID width.
- TIMEOUT_CYCLES, 64: watchdog limit. 0 disables the watchdog.
- clk_i  in  1  clock; one clock domain. Reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester check request. Held high until the matching rsp_valid_o.
- req_addr_i  in  NUM_REQ×ADDR_WIDTH  per-requester address.
- req_num_bytes_i  in  NUM_REQ×($clog2(DATA_WIDTH/8)+1)  per-requester byte count.
- req_sid_i  in  NUM_REQ×SID_WIDTH  per-requester source ID.
- req_access_i  in  NUM_REQ×rv_iopmp_pkg::access_t  per-requester access type.
- rsp_valid_o  out  NUM_REQ  one-hot, single-cycle result strobe.
- rsp_allow_o  out  1  result; meaningful only when rsp_valid_o is nonzero.
- tl_en_o  out  1  transaction enable to the checker.
- tl_addr_o / tl_num_bytes_o / tl_sid_o / tl_access_o  out  as above  latched fields to the checker.
- tl_ready_i  in  1  checker accepts when tl_en_o && tl_ready_i.
- tl_valid_i  in  1  checker result strobe.
- tl_allow_i  in  1  checker result.
- grant_o  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy_o  out  1  high in every state other than IDLE.
- timeout_o  out  1  single-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding is arb_state_e.
- IDLE
  - If any req_valid_i is high, pick the winner by round robin.
  - The search starts at index rr_ptr and wraps modulo NUM_REQ.
  - Latch the winner's fields and its index into grant_o, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE
  - tl_en_o=1 with the latched fields stable.
  - On tl_ready_i=1, go to WAIT. tl_en_o is therefore high for exactly the accept cycles.
  - tl_valid_i is ignored in this state.
- WAIT
  - On tl_valid_i=1, latch tl_allow_i and go to RESP.
- Watchdog
  - Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on leaving IDLE and increments every cycle in ISSUE and WAIT.
  - When the count reaches TIMEOUT_CYCLES, it latches allow=0, pulses timeout_o and goes to RESP.
  - If tl_valid_i arrives in the same cycle the limit is reached, tl_valid_i wins and timeout_o stays 0.
  - After a timeout in ISSUE, tl_en_o drops.
  - After a timeout, a late tl_valid_i is ignored, including while in IDLE.
- RESP
  - rsp_valid_o[grant]=1 and rsp_allow_o = latched allow for exactly one cycle.
  - Set rr_ptr to (grant+1) mod NUM_REQ and go to IDLE.
  - A new grant is possible in the next cycle.
- A requester that drops req_valid_i mid-check still receives its rsp_valid_o pulse; the arbiter never aborts a check.
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NUM_REQ-1,0.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, grant_o=0, counter=0, latched allow=0.
  - tl_en_o=0 and all tl_* field outputs=0.
  - rsp_valid_o=0, rsp_allow_o=0, busy_o=0, timeout_o=0.
- Reset mid-check: return to IDLE next cycle. No response is emitted, and a pending checker result is dropped.
- Latency with tl_ready_i tied high and the checker answering k cycles after accept:
  - Request seen in IDLE at cycle 0.
  - tl_en_o at cycle 1.
  - tl_valid_i at cycle 1+k.
  - rsp_valid_o at cycle 2+k.
  - Minimum request-to-response is 3 cycles (k=1).
- Back-to-back throughput: one check per (k+3) cycles.
- All outputs are registered, or decoded directly from state registers. There are no combinational paths from req_*_i to any output.

## Structure
- rv_iopmp_pkg gains arb_state_e, plus check_req_t (addr, num_bytes, sid, access), which is used for the latch.
- Sub-module rv_iopmp_rr_picker: combinational round-robin pick.
  - Inputs: NUM_REQ request vector and rr_ptr.
  - Outputs: any_o and idx_o.
  - Reused by later multi-instance checker sharing.

## Test plan
- Single request: NUM_REQ=2, req_valid_i=2'b01, addr=0x8000_0000, tl_ready_i=1, checker returns allow=1 with k=1 → tl_en_o at cycle 1 with addr 0x8000_0000, rsp_valid_o=2'b01 and rsp_allow_o=1 at cycle 3.
- Fairness: both requesters held high for 6 checks → grant sequence 0,1,0,1,0,1, with each rsp_valid_o bit one-hot on its own turn.
- Backpressure: tl_ready_i low for 5 cycles → tl_en_o and tl_addr_o stable for 6 cycles, then the FSM moves to WAIT.
- Timeout: TIMEOUT_CYCLES=8, checker never answers → timeout_o and rsp_valid_o pulse 8 cycles after leaving IDLE, with rsp_allow_o=0. A late tl_valid_i=1 produces no response.
- Collision: tl_valid_i=1 with tl_allow_i=1 in the exact cycle the counter reaches TIMEOUT_CYCLES → rsp_allow_o=1 and timeout_o=0.
- Reset mid-WAIT: assert rst_i for 1 cycle → busy_o=0 and rsp_valid_o never pulses. The next request is granted to requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_iopmp_pkg
// Description : Shared IOPMP types: access kinds, arbiter states and the
//               latched check request.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_iopmp_pkg;

   localparam int unsigned IOPMP_ADDR_WIDTH = 64;
   localparam int unsigned IOPMP_DATA_WIDTH = 64;
   localparam int unsigned IOPMP_NB_WIDTH   = $clog2(IOPMP_DATA_WIDTH / 8) + 1;
   localparam int unsigned IOPMP_SID_WIDTH  = 1;

   typedef enum logic [1:0] {
      ACCESS_NONE  = 2'b00,
      ACCESS_READ  = 2'b01,
      ACCESS_WRITE = 2'b10,
      ACCESS_EXEC  = 2'b11
   } access_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_ISSUE = 2'b01,
      ARB_WAIT  = 2'b10,
      ARB_RESP  = 2'b11
   } arb_state_e;

   typedef struct packed {
      logic [IOPMP_ADDR_WIDTH-1:0] addr;
      logic [IOPMP_NB_WIDTH-1:0]   num_bytes;
      logic [IOPMP_SID_WIDTH-1:0]  sid;
      access_t                     access;
   } check_req_t;

endpackage : rv_iopmp_pkg
`default_nettype wire

// File: rtl/rv_iopmp_check_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_iopmp_check_arbiter_if
// Description : Requester-side and checker-side bundle of the shared checker
//               arbiter. master = surrounding system, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_iopmp_check_arbiter_if #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SID_WIDTH  = 1
);
   import rv_iopmp_pkg::*;

   localparam int unsigned c_NB_W = $clog2(DATA_WIDTH / 8) + 1;

   logic [NUM_REQ-1:0]                 req_valid_i;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ-1:0][c_NB_W-1:0]     req_num_bytes_i;
   logic [NUM_REQ-1:0][SID_WIDTH-1:0]  req_sid_i;
   access_t [NUM_REQ-1:0]              req_access_i;
   logic [NUM_REQ-1:0]                 rsp_valid_o;
   logic                               rsp_allow_o;

   logic                               tl_en_o;
   logic [ADDR_WIDTH-1:0]              tl_addr_o;
   logic [c_NB_W-1:0]                  tl_num_bytes_o;
   logic [SID_WIDTH-1:0]               tl_sid_o;
   access_t                            tl_access_o;
   logic                               tl_ready_i;
   logic                               tl_valid_i;
   logic                               tl_allow_i;

   modport master (
      output req_valid_i, req_addr_i, req_num_bytes_i, req_sid_i, req_access_i,
      input  rsp_valid_o, rsp_allow_o,
      input  tl_en_o, tl_addr_o, tl_num_bytes_o, tl_sid_o, tl_access_o,
      output tl_ready_i, tl_valid_i, tl_allow_i
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_num_bytes_i, req_sid_i, req_access_i,
      output rsp_valid_o, rsp_allow_o,
      output tl_en_o, tl_addr_o, tl_num_bytes_o, tl_sid_o, tl_access_o,
      input  tl_ready_i, tl_valid_i, tl_allow_i
   );

endinterface : rv_iopmp_check_arbiter_if
`default_nettype wire

// File: rtl/rv_iopmp_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rv_iopmp_rr_picker
// Description : Combinational round-robin pick: first active request found
//               scanning upward from rr_ptr_i, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_iopmp_rr_picker #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [IDX_WIDTH-1:0] rr_ptr_i,
   output logic                 any_o,
   output logic [IDX_WIDTH-1:0] idx_o
);

   localparam int unsigned c_POS_W = IDX_WIDTH + 1;

   logic [c_POS_W-1:0] w_pos;

   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      w_pos = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // One conditional subtract is enough: rr_ptr_i + i < 2*NUM_REQ.
         w_pos = {1'b0, rr_ptr_i} + c_POS_W'(i);
         if (w_pos >= c_POS_W'(NUM_REQ)) begin
            w_pos = w_pos - c_POS_W'(NUM_REQ);
         end
         if (!any_o && req_i[w_pos[IDX_WIDTH-1:0]]) begin
            any_o = 1'b1;
            idx_o = w_pos[IDX_WIDTH-1:0];
         end
      end
   end

endmodule : rv_iopmp_rr_picker
`default_nettype wire

// File: rtl/rv_iopmp_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv_iopmp_check_arbiter
// Description : Round-robin sharing of one IOPMP transaction checker among
//               NUM_REQ requesters, with a watchdog that denies stuck checks.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_iopmp_check_arbiter
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned SID_WIDTH      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   rv_iopmp_check_arbiter_if.slave    bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_o,
   output logic                       busy_o,
   output logic                       timeout_o
);

   localparam int unsigned        c_IDX_W    = $clog2(NUM_REQ);
   localparam int unsigned        c_NB_W     = $clog2(DATA_WIDTH / 8) + 1;
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

   arb_state_e         r_state;
   arb_state_e         w_state_next;
   logic [c_IDX_W-1:0] r_rr_ptr;
   logic [c_IDX_W-1:0] r_grant;
   check_req_t         r_req;
   logic               r_allow;
   logic               r_timeout;

   logic               w_any;
   logic [c_IDX_W-1:0] w_pick_idx;
   logic               w_wdog_hit;
   logic               w_timeout_fire;
   logic               w_tl_en;
   logic               w_busy;
   logic [NUM_REQ-1:0] w_rsp_valid;
   logic               w_rsp_allow;

   rv_iopmp_rr_picker #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (c_IDX_W)
   ) u_picker (
      .req_i    (bus.req_valid_i),
      .rr_ptr_i (r_rr_ptr),
      .any_o    (w_any),
      .idx_o    (w_pick_idx)
   );

   // The watchdog fires on the cycle its count reaches TIMEOUT_CYCLES, i.e.
   // the last of TIMEOUT_CYCLES consecutive ISSUE/WAIT cycles.
   if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
      localparam int unsigned        c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

      logic [c_CNT_W-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_cnt <= '0;
         end else if (r_state == ARB_IDLE) begin
            r_cnt <= '0;
         end else if (r_state == ARB_ISSUE || r_state == ARB_WAIT) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end

      assign w_wdog_hit = (r_state == ARB_ISSUE || r_state == ARB_WAIT) &&
                          (r_cnt == c_LAST);
   end else begin : g_wdog_off
      assign w_wdog_hit = 1'b0;
   end

   // A checker answer in the limit cycle takes precedence over the watchdog.
   assign w_timeout_fire = w_wdog_hit &&
                           ((r_state == ARB_ISSUE) ||
                            (r_state == ARB_WAIT && !bus.tl_valid_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_state_next = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (w_wdog_hit) begin
               w_state_next = ARB_RESP;
            end else if (bus.tl_ready_i) begin
               w_state_next = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (bus.tl_valid_i || w_wdog_hit) begin
               w_state_next = ARB_RESP;
            end
         end
         ARB_RESP: begin
            w_state_next = ARB_IDLE;
         end
         default: begin
            w_state_next = ARB_IDLE;
         end
      endcase
   end

   always_comb begin
      w_tl_en     = 1'b0;
      w_busy      = 1'b1;
      w_rsp_valid = '0;
      w_rsp_allow = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            w_busy = 1'b0;
         end
         ARB_ISSUE: begin
            w_tl_en = 1'b1;
         end
         ARB_RESP: begin
            w_rsp_valid[r_grant] = 1'b1;
            w_rsp_allow          = r_allow;
         end
         default: begin
            w_busy = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_req     <= '0;
         r_allow   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_fire;
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_grant         <= w_pick_idx;
                  r_req.addr      <= IOPMP_ADDR_WIDTH'(bus.req_addr_i[w_pick_idx]);
                  r_req.num_bytes <= IOPMP_NB_WIDTH'(bus.req_num_bytes_i[w_pick_idx]);
                  r_req.sid       <= IOPMP_SID_WIDTH'(bus.req_sid_i[w_pick_idx]);
                  r_req.access    <= bus.req_access_i[w_pick_idx];
               end
            end
            ARB_ISSUE: begin
               if (w_wdog_hit) begin
                  r_allow <= 1'b0;
               end
            end
            ARB_WAIT: begin
               if (bus.tl_valid_i) begin
                  r_allow <= bus.tl_allow_i;
               end else if (w_wdog_hit) begin
                  r_allow <= 1'b0;
               end
            end
            ARB_RESP: begin
               r_rr_ptr <= (r_grant == c_LAST_IDX) ? '0 : r_grant + c_IDX_W'(1);
            end
            default: begin
               r_allow <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tl_en_o        = w_tl_en;
   assign bus.tl_addr_o      = ADDR_WIDTH'(r_req.addr);
   assign bus.tl_num_bytes_o = c_NB_W'(r_req.num_bytes);
   assign bus.tl_sid_o       = SID_WIDTH'(r_req.sid);
   assign bus.tl_access_o    = r_req.access;
   assign bus.rsp_valid_o    = w_rsp_valid;
   assign bus.rsp_allow_o    = w_rsp_allow;
   assign grant_o            = r_grant;
   assign busy_o             = w_busy;
   assign timeout_o          = r_timeout;

endmodule : rv_iopmp_check_arbiter
`default_nettype wire

// File: tb/tb_rv_iopmp_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_iopmp_check_arbiter
// Description : Self-checking bench for the shared-checker arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_iopmp_check_arbiter;
   import rv_iopmp_pkg::*;

   localparam int NUM_REQ    = 2;
   localparam int ADDR_WIDTH = 64;
   localparam int DATA_WIDTH = 64;
   localparam int SID_WIDTH  = 1;
   localparam int TIMEOUT    = 8;
   localparam int NB_W       = $clog2(DATA_WIDTH / 8) + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [0:0] grant;
   logic       busy;
   logic       timeout;

   rv_iopmp_check_arbiter_if #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SID_WIDTH(SID_WIDTH)
   ) bus ();

   rv_iopmp_check_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .SID_WIDTH(SID_WIDTH), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int m_ptr    = 0;

   logic [ADDR_WIDTH-1:0] f_addr [NUM_REQ];
   logic [NB_W-1:0]       f_nb   [NUM_REQ];
   logic [SID_WIDTH-1:0]  f_sid  [NUM_REQ];
   access_t               f_acc  [NUM_REQ];

   typedef struct {
      logic [1:0]  mask;
      logic [63:0] addr;
      int          d;
      int          k;
      logic        allow;
      int          grant;
      int          lat;
      logic        exp_allow;
      logic        exp_to;
      int          en;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_pick(input logic [1:0] mask, input int ptr);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mask[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic set_fields(input logic [63:0] fixed_addr, input int slot);
      for (int i = 0; i < NUM_REQ; i++) begin
         f_addr[i] = {$urandom, $urandom};
         f_nb[i]   = NB_W'($urandom_range(0, 8));
         f_sid[i]  = SID_WIDTH'($urandom);
         f_acc[i]  = access_t'(2'($urandom));
      end
      if (fixed_addr != 0) f_addr[slot] = fixed_addr;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_addr_i[i]      = f_addr[i];
         bus.req_num_bytes_i[i] = f_nb[i];
         bus.req_sid_i[i]       = f_sid[i];
         bus.req_access_i[i]    = f_acc[i];
      end
   endtask

   // One check: ready held low for d ISSUE cycles, answer k cycles after accept.
   task automatic do_check(input string name, input logic [1:0] mask, input logic [63:0] addr,
                           input int d, input int k, input logic allow_in, input int exp_grant,
                           input int exp_lat, input logic exp_allow, input logic exp_to, input int exp_en);
      int waitc, horizon, lat, first_en, en_cnt, rsp_cnt, to_cnt, bad_field, g_at;
      logic [NUM_REQ-1:0] vec, exp_vec;
      logic allow_s, to_s;
      waitc = 0; lat = -1; first_en = -1; en_cnt = 0; rsp_cnt = 0; to_cnt = 0; bad_field = 0;
      g_at = -1; vec = '0; allow_s = 1'b0; to_s = 1'b0;
      @(negedge clk);
      while (busy && waitc < 50) begin @(negedge clk); waitc++; end
      check({name, " idle before"}, 64'(busy), 64'(0));
      set_fields(addr, exp_grant);
      bus.req_valid_i = mask;
      bus.tl_ready_i  = 1'b0;
      bus.tl_valid_i  = 1'b0;
      horizon = ((TIMEOUT + 1) > (d + k + 1) ? (TIMEOUT + 1) : (d + k + 1)) + 3;
      for (int c = 1; c <= horizon; c++) begin
         @(negedge clk);
         if (bus.tl_en_o) begin
            en_cnt++;
            if (first_en < 0) first_en = c;
            if (bus.tl_addr_o !== f_addr[exp_grant] || bus.tl_num_bytes_o !== f_nb[exp_grant] ||
                bus.tl_sid_o !== f_sid[exp_grant] || bus.tl_access_o !== f_acc[exp_grant])
               bad_field++;
         end
         if (bus.rsp_valid_o != '0) begin
            rsp_cnt++;
            if (lat < 0) begin
               lat = c; vec = bus.rsp_valid_o; allow_s = bus.rsp_allow_o;
               to_s = timeout; g_at = int'(grant);
            end
         end
         if (timeout) to_cnt++;
         if (lat >= 0) bus.req_valid_i = '0;
         bus.tl_ready_i = (c - 1 >= d);
         bus.tl_valid_i = (c - 1 == d + k);
         bus.tl_allow_i = (c - 1 == d + k) ? allow_in : 1'($urandom);
      end
      bus.req_valid_i = '0;
      bus.tl_ready_i  = 1'b0;
      bus.tl_valid_i  = 1'b0;
      exp_vec = '0;
      exp_vec[exp_grant] = 1'b1;
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " grant"}, 64'(g_at), 64'(exp_grant));
      check({name, " rsp_valid"}, 64'(vec), 64'(exp_vec));
      check({name, " rsp_allow"}, 64'(allow_s), 64'(exp_allow));
      check({name, " timeout at rsp"}, 64'(to_s), 64'(exp_to));
      check({name, " timeout pulses"}, 64'(to_cnt), 64'(exp_to));
      check({name, " rsp pulses"}, 64'(rsp_cnt), 64'(1));
      check({name, " tl_en cycles"}, 64'(en_cnt), 64'(exp_en));
      check({name, " tl_en first cycle"}, 64'(first_en), 64'(1));
      check({name, " tl fields"}, 64'(bad_field), 64'(0));
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
   endtask

   vec_t tbl [9];

   initial begin
      int w, d, k, lat, en;
      logic [1:0] mask;
      logic allow, ok;
      bus.req_valid_i = '0; bus.tl_ready_i = 1'b0; bus.tl_valid_i = 1'b0; bus.tl_allow_i = 1'b0;
      set_fields(64'h0, 0);

      //             mask   addr           d   k   alw   grant lat  e_alw e_to en
      tbl[0] = '{2'b01, 64'h8000_0000, 0,  1,  1'b1, 0,    3,   1'b1, 1'b0, 1};
      tbl[1] = '{2'b11, 64'h0,         0,  2,  1'b0, 1,    4,   1'b0, 1'b0, 1};
      tbl[2] = '{2'b10, 64'h0,         5,  2,  1'b1, 1,    9,   1'b1, 1'b0, 6};
      tbl[3] = '{2'b11, 64'h0,         0,  20, 1'b1, 0,    9,   1'b0, 1'b1, 1};
      tbl[4] = '{2'b11, 64'h0,         0,  7,  1'b1, 1,    9,   1'b1, 1'b0, 1};
      tbl[5] = '{2'b11, 64'h0,         0,  8,  1'b1, 0,    9,   1'b0, 1'b1, 1};
      tbl[6] = '{2'b01, 64'h0,         10, 1,  1'b1, 0,    9,   1'b0, 1'b1, 8};
      tbl[7] = '{2'b10, 64'h0,         7,  1,  1'b1, 1,    9,   1'b0, 1'b1, 8};
      tbl[8] = '{2'b11, 64'h0,         1,  3,  1'b1, 0,    6,   1'b1, 1'b0, 2};

      // Reset state, sampled while reset is held.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'(0));
      check("reset tl_en", 64'(bus.tl_en_o), 64'(0));
      check("reset tl_addr", 64'(bus.tl_addr_o), 64'(0));
      check("reset tl_num_bytes", 64'(bus.tl_num_bytes_o), 64'(0));
      check("reset rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
      check("reset rsp_allow", 64'(bus.rsp_allow_o), 64'(0));
      check("reset grant", 64'(grant), 64'(0));
      check("reset timeout", 64'(timeout), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_check($sformatf("vec%0d", i), tbl[i].mask, tbl[i].addr, tbl[i].d, tbl[i].k, tbl[i].allow,
                  tbl[i].grant, tbl[i].lat, tbl[i].exp_allow, tbl[i].exp_to, tbl[i].en);
         m_ptr = (tbl[i].grant + 1) % NUM_REQ;
      end

      // Randomized checks against the transaction-level model.
      for (int i = 0; i < 20; i++) begin
         mask  = 2'($urandom_range(1, 3));
         d     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 3));
         k     = int'($urandom_range(1, 10));
         allow = 1'($urandom);
         w     = model_pick(mask, m_ptr);
         ok    = (d + k <= TIMEOUT - 1);
         lat   = ok ? d + k + 2 : TIMEOUT + 1;
         en    = ok ? d + 1 : ((d + 1) < TIMEOUT ? d + 1 : TIMEOUT);
         do_check($sformatf("rnd%0d", i), mask, 64'h0, d, k, allow, w, lat, ok & allow, !ok, en);
         m_ptr = (w + 1) % NUM_REQ;
      end

      // Fairness: both held, checker answers one cycle after accept.
      apply_reset();
      begin
         int got_idx [6];
         int got_cyc [6];
         int n, exp_w;
         logic prev_en;
         n = 0; prev_en = 1'b0;
         set_fields(64'h0, 0);
         bus.req_valid_i = 2'b11;
         bus.tl_ready_i  = 1'b1;
         for (int c = 1; c <= 60 && n < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid_o != '0) begin
               got_cyc[n] = c;
               got_idx[n] = (bus.rsp_valid_o == 2'b01) ? 0 : (bus.rsp_valid_o == 2'b10) ? 1 : -1;
               n++;
               if (n == 6) bus.req_valid_i = '0;
            end
            bus.tl_valid_i = prev_en;
            bus.tl_allow_i = 1'($urandom);
            prev_en = bus.tl_en_o;
         end
         bus.tl_valid_i = 1'b0;
         bus.tl_ready_i = 1'b0;
         check("fair response count", 64'(n), 64'(6));
         for (int i = 0; i < n; i++) begin
            exp_w = model_pick(2'b11, m_ptr);
            m_ptr = (exp_w + 1) % NUM_REQ;
            check($sformatf("fair grant %0d", i), 64'(got_idx[i]), 64'(exp_w));
            check($sformatf("fair cycle %0d", i), 64'(got_cyc[i]), 64'(3 + 4 * i));
         end
      end

      // Reset while waiting for the checker: nothing may come back.
      do_check("pre-reset", 2'b01, 64'h0, 0, 1, 1'b1, model_pick(2'b01, m_ptr), 3, 1'b1, 1'b0, 1);
      m_ptr = (model_pick(2'b01, m_ptr) + 1) % NUM_REQ;
      begin
         int rsp_seen;
         rsp_seen = 0;
         @(negedge clk);
         set_fields(64'h0, 0);
         bus.req_valid_i = 2'b11;
         @(negedge clk);
         bus.tl_ready_i = 1'b1;
         @(negedge clk);
         check("mid-wait busy", 64'(busy), 64'(1));
         check("mid-wait tl_en", 64'(bus.tl_en_o), 64'(0));
         rst = 1'b1;
         @(negedge clk);
         check("after reset busy", 64'(busy), 64'(0));
         check("after reset grant", 64'(grant), 64'(0));
         rst = 1'b0;
         m_ptr = 0;
         bus.req_valid_i = '0;
         bus.tl_ready_i  = 1'b0;
         bus.tl_valid_i  = 1'b1;
         bus.tl_allow_i  = 1'b1;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid_o != '0) rsp_seen++;
            bus.tl_valid_i = 1'b0;
         end
         check("no rsp after reset", 64'(rsp_seen), 64'(0));
      end
      do_check("post-reset", 2'b11, 64'h0, 0, 1, 1'b1, model_pick(2'b11, m_ptr), 3, 1'b1, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global time limit: simulation did not finish");
      $fatal(1, "time limit exceeded");
   end

endmodule : tb_rv_iopmp_check_arbiter
`default_nettype wire
